fir_operand_fifo: RTL and testbench
===================================

// Module: fir_operand_fifo
// PURPOSE
//   Elastic buffer directly downstream of the two operand posit decoders. Captures {op, fir1, fir2}
//   plus zero/NaR flags derived from the raw posit bits, and presents them to the PPU core stage.
//   Decouples the decode front-end from core stalls with a valid/ready handshake and DEPTH entries.
// PARAMETERS
//   N      16  posit width (sizes posit_t / fir_t via ppu_pkg)
//   ES     1   exponent field width (sizes fir_t via ppu_pkg)
//   DEPTH  4   number of entries; power of two, >= 2
// PORTS
//   clk_i        in   1                   clock, all state on rising edge
//   rst_i        in   1                   synchronous reset, active-high
//   flush_i      in   1                   synchronous discard of all entries
//   in_valid_i   in   1                   upstream entry valid
//   in_ready_o   out  1                   buffer can accept (not full)
//   op_i         in   ppu_pkg::operation_e requested operation
//   p1_i, p2_i   in   posit_t (N)         raw operands (for special-case flags only)
//   fir1_i       in   fir_t               decoded operand 1
//   fir2_i       in   fir_t               decoded operand 2
//   out_valid_o  out  1                   head entry valid
//   out_ready_i  in   1                   downstream accepts head
//   op_o         out  operation_e         head operation
//   fir1_o       out  fir_t               head operand 1
//   fir2_o       out  fir_t               head operand 2
//   zero_o       out  2                   [i]=1: operand i+1 is posit zero (all bits 0)
//   nar_o        out  2                   [i]=1: operand i+1 is NaR (MSB 1, rest 0)
//   count_o      out  $clog2(DEPTH)+1     occupancy
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, count_o=0, out_valid_o=0, in_ready_o=1.
//     All data outputs read 0 while empty; storage contents are don't-care.
//   - push = in_valid_i & in_ready_o.
//     pop  = out_valid_o & out_ready_i.
//     Both evaluate in the same cycle.
//   - in_ready_o = (count != DEPTH).
//     Depends on registered count only; no combinational path from out_ready_i.
//   - out_valid_o = (count != 0).
//     Outputs are driven from storage[rd_ptr]; no input-to-output combinational path.
//   - Latency: an entry pushed at edge t is visible on the outputs after edge t (one cycle),
//     including when the buffer was empty.
//   - zero/nar flags are computed from p1_i/p2_i at push time and stored with the entry.
//   - Occupancy states: EMPTY (0), PARTIAL, FULL (DEPTH).
//     - push only: count+1.
//     - pop only: count-1.
//     - push&pop: count unchanged, both pointers advance (legal in PARTIAL only).
//       In FULL, push is blocked because in_ready_o=0.
//   - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - flush_i: next cycle count=0, pointers=0, out_valid_o=0; same-cycle push/pop are ignored.
//   - Priority: rst_i > flush_i > push/pop. Reset mid-transfer drops all entries, no partial output.
//   - Handshake rules:
//     - While out_valid_o=1 and out_ready_i=0, head outputs are held stable.
//     - A bench must not change in_* while in_valid_i=1 and in_ready_o=0.
// TESTING
//   1. Reset, single push (op=ADD, p1=16'h4000, p2=16'h0000) -> next cycle out_valid_o=1,
//      zero_o=2'b10, nar_o=2'b00, count_o=1.
//   2. DEPTH=4: push 4 with out_ready_i=0 -> count_o=4, in_ready_o=0; 5th valid held off;
//      then pop 4 -> order preserved 1..4.
//   3. Continuous push+pop with out_ready_i=1 for 20 entries -> count_o steady at 1;
//      pointers wrap several times; output sequence equals input sequence.
//   4. p1=16'h8000 -> nar_o[0]=1.
//      p1=16'h8001 -> nar_o[0]=0, zero_o[0]=0.
//   5. Fill to 3, assert flush_i together with in_valid_i -> next cycle count_o=0,
//      out_valid_o=0; the flushed-cycle entry is never output.
//   6. rst_i asserted while FULL with out_ready_i=1 -> next cycle count_o=0,
//      out_valid_o=0, in_ready_o=1; no pop observed.

Source files
------------

// File: rtl/fir_operand_fifo.sv
// Operand elastic buffer between the posit decoders and the PPU core stage.
// Holds {op, fir1, fir2} plus zero/NaR flags taken from the raw posit bits.
// The flags are computed once, when the entry is pushed.

package ppu_pkg;
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } operation_e;

  // Decoded operand (fir) layout: {sign, total exponent, mantissa}.
  // The total exponent holds regime*2^ES + exp, with one extra bit for the sign.
  // The mantissa keeps the hidden bit.
  function automatic int fir_w(int n, int es);
    return 1 + (es + $clog2(n) + 1) + (n - es - 2);
  endfunction
endpackage

module fir_operand_fifo
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  operation_e                op_i,
  input  logic [N-1:0]              p1_i,
  input  logic [N-1:0]              p2_i,
  input  logic [fir_w(N,ES)-1:0]    fir1_i,
  input  logic [fir_w(N,ES)-1:0]    fir2_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output operation_e                op_o,
  output logic [fir_w(N,ES)-1:0]    fir1_o,
  output logic [fir_w(N,ES)-1:0]    fir2_o,
  output logic [1:0]                zero_o,
  output logic [1:0]                nar_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int FW = fir_w(N, ES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    operation_e    op;
    logic [FW-1:0] fir1;
    logic [FW-1:0] fir2;
    logic [1:0]    zero;
    logic [1:0]    nar;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Ready and valid come only from the registered count.
  // This keeps out_ready_i from reaching in_ready_o combinationally.
  assign in_ready_o  = (count != CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count;

  // Bit [0] of each flag pair refers to operand 1.
  assign wr_entry.op   = op_i;
  assign wr_entry.fir1 = fir1_i;
  assign wr_entry.fir2 = fir2_i;
  assign wr_entry.zero = {p2_i == '0, p1_i == '0};
  assign wr_entry.nar  = {p2_i == NAR, p1_i == NAR};

  // Update the pointers and occupancy.
  // Reset takes priority over flush, and flush over any push or pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write storage.
  // The storage has no reset because stale slots are never presented.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i && !flush_i) mem[wr_ptr] <= wr_entry;
  end

  // Present the head entry straight from storage.
  // All outputs are forced to zero while the buffer is empty.
  always_comb begin
    head = mem[rd_ptr];
    if (!out_valid_o) head = '0;
  end

  assign op_o   = head.op;
  assign fir1_o = head.fir1;
  assign fir2_o = head.fir2;
  assign zero_o = head.zero;
  assign nar_o  = head.nar;

endmodule

// File: tb/tb_fir_operand_fifo.sv
// Randomised bench for fir_operand_fifo against a queue-based reference model.
module tb_fir_operand_fifo;
  import ppu_pkg::*;

  localparam int N     = 16;
  localparam int ES    = 1;
  localparam int DEPTH = 4;
  localparam int FW    = fir_w(N, ES);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = 1 + 1 + CW + 2 + FW + FW + 2 + 2;
  localparam logic [N-1:0] NAR = 16'h8000;

  typedef struct packed {
    logic [1:0]    op;
    logic [FW-1:0] f1;
    logic [FW-1:0] f2;
    logic [N-1:0]  p1;
    logic [N-1:0]  p2;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  ent_t cur = '0;

  logic             in_ready, out_valid;
  operation_e       op_o;
  logic [FW-1:0]    fir1_o, fir2_o;
  logic [1:0]       zero_o, nar_o;
  logic [CW-1:0]    count_o;

  int   checks = 0, failures = 0;
  ent_t q[$];
  bit   last_push;

  always #5 clk = ~clk;

  fir_operand_fifo #(.N(N), .ES(ES), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(operation_e'(cur.op)), .p1_i(cur.p1), .p2_i(cur.p2),
    .fir1_i(cur.f1), .fir2_i(cur.f2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op_o(op_o), .fir1_o(fir1_o), .fir2_o(fir2_o),
    .zero_o(zero_o), .nar_o(nar_o), .count_o(count_o)
  );

  // Reference model: FIFO queue, updated from the inputs seen at the rising edge.
  task automatic step();
    bit rdy, vld, push, pop;
    @(posedge clk);
    rdy  = q.size() < DEPTH;
    vld  = q.size() > 0;
    push = in_valid && rdy;
    pop  = vld && out_ready;
    last_push = 1'b0;
    if (rst || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin q.push_back(cur); last_push = 1'b1; end
    end
    #1;
  endtask

  function automatic logic [OW-1:0] exp_vec();
    ent_t h;
    logic [1:0] z, n;
    if (q.size() == 0) return {1'b0, 1'b1, CW'(0), 2'b00, FW'(0), FW'(0), 2'b00, 2'b00};
    h = q[0];
    z = {h.p2 == 0, h.p1 == 0};
    n = {h.p2 == NAR, h.p1 == NAR};
    return {1'b1, q.size() < DEPTH, CW'(q.size()), h.op, h.f1, h.f2, z, n};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {out_valid, in_ready, count_o, op_o, fir1_o, fir2_o, zero_o, nar_o};
  endfunction

  function automatic logic [N-1:0] rand_posit();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return NAR;
      2:       return 16'h8001;
      default: return N'($urandom);
    endcase
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.op = 2'($urandom_range(0, 3));
    e.f1 = FW'($urandom);
    e.f2 = FW'($urandom);
    e.p1 = rand_posit();
    e.p2 = rand_posit();
    return e;
  endfunction

  task automatic test_reset();
    logic [OW-1:0] o;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    o = obs_vec();
    if (o !== {1'b0, 1'b1, CW'(0), 2'b00, FW'(0), FW'(0), 2'b00, 2'b00}) begin
      failures++; $display("FAIL reset_state got=%h want=%h", o, exp_vec());
    end
    checks++;
  endtask

  task automatic test_single_push();
    cur = '{op: 2'(ADD), f1: FW'($urandom), f2: FW'($urandom), p1: 16'h4000, p2: 16'h0000};
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    if ({out_valid, count_o, zero_o, nar_o} !== {1'b1, CW'(1), 2'b10, 2'b00}) begin
      failures++;
      $display("FAIL single_push got v=%b cnt=%0d z=%b n=%b want v=1 cnt=1 z=10 n=00",
               out_valid, count_o, zero_o, nar_o);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL single_push_head got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL single_pop got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_fill_drain();
    logic [OW-1:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cur = rand_ent(); in_valid = 1'b1;
      step();
    end
    if ({count_o, in_ready} !== {CW'(DEPTH), 1'b0}) begin
      failures++; $display("FAIL fill_full got cnt=%0d rdy=%b want cnt=%0d rdy=0", count_o, in_ready, DEPTH);
    end
    checks++;
    // The fifth entry is offered and held while the buffer stays full.
    cur = rand_ent();
    held = obs_vec();
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs_vec() !== held || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL full_hold got=%h want=%h", obs_vec(), exp_vec());
      end
      checks++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      step();
      if (last_push) in_valid = 1'b0;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL drain_order cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cur = rand_ent();
      step();
      if (obs_vec() !== exp_vec() || count_o !== CW'(1)) begin
        failures++; $display("FAIL back_to_back i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL b2b_empty got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_flags();
    logic [N-1:0] pv [2];
    logic [1:0]   wn [2];
    logic [1:0]   wz [2];
    pv[0] = 16'h8000; wn[0] = 2'b01; wz[0] = 2'b00;
    pv[1] = 16'h8001; wn[1] = 2'b00; wz[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cur = rand_ent(); cur.p1 = pv[i]; cur.p2 = 16'h1234;
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      if ({nar_o, zero_o} !== {wn[i], wz[i]}) begin
        failures++; $display("FAIL flags p1=%h got n=%b z=%b want n=%b z=%b", pv[i], nar_o, zero_o, wn[i], wz[i]);
      end
      checks++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = rand_ent(); in_valid = 1'b1;
      step();
    end
    cur = rand_ent(); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    if ({count_o, out_valid} !== {CW'(0), 1'b0} || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL flush got cnt=%0d v=%b want cnt=0 v=0", count_o, out_valid);
    end
    checks++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_leak got v=%b want v=0", out_valid);
      end
      checks++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cur = rand_ent(); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    if ({count_o, out_valid, in_ready} !== {CW'(0), 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_full got cnt=%0d v=%b r=%b want cnt=0 v=0 r=1", count_o, out_valid, in_ready);
    end
    checks++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      // Inputs change only when the previous offer was not stalled.
      if (!(in_valid && q.size() >= DEPTH)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        cur = rand_ent();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
      flush = 1'b0;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flags();
    test_flush();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
